// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage buffer: occupancy states,
// default bubble instruction and a reference entry layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  localparam int unsigned DEF_INST_W = 32;
  localparam int unsigned DEF_PC_W   = 32;

  localparam logic [DEF_INST_W-1:0] NOP_INST_DEFAULT = '0;

  // Reference layout at default widths; instances re-declare it at their own widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_PC_W-1:0]   npc;
  } pipe_entry_t;

  function automatic logic occ_accepts(input occ_state_e st);
    return st != FULL;
  endfunction

endpackage

// File: rtl/pipeline_stage_buffer_if.sv
// Handshake bundle for pipeline_stage_buffer: upstream offer side and
// downstream presentation side. The buffer uses the slave modport.
interface pipeline_stage_buffer_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_npc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_npc;

  modport master (
    output in_valid, in_inst, in_npc, out_ready,
    input  in_ready, out_valid, out_inst, out_npc
  );

  modport slave (
    input  in_valid, in_inst, in_npc, out_ready,
    output in_ready, out_valid, out_inst, out_npc
  );
endinterface

// File: rtl/pipeline_stage_buffer_sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Two-entry (head + skid) pipeline register with valid/ready, stall hold and flush.
// Define STAGE_BUF_PERF_EN to add saturating stall/flush cycle counters.
module pipeline_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  pipeline_stage_buffer_if.slave   bus
`ifdef STAGE_BUF_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   npc;
  } entry_t;

  occ_state_e state_q, state_d;
  entry_t     h_q, h_d;
  entry_t     s_q, s_d;
  logic       in_ready_q, in_ready_d;

  logic       out_valid;
  logic       in_ready;
  logic       enq;
  logic       deq;
  entry_t     in_entry;

  // in_ready comes only from a flop and stall, never from out_ready.
  assign in_ready  = in_ready_q & ~stall;
  assign out_valid = h_q.valid & ~stall;

  always_comb begin
    in_entry = '{valid: 1'b1, inst: bus.in_inst, npc: bus.in_npc};
    enq      = bus.in_valid & in_ready & ~flush;
    deq      = out_valid & bus.out_ready;

    state_d  = state_q;
    h_d      = h_q;
    s_d      = s_q;

    if (flush) begin
      // The bubble keeps the incoming next-PC, as the old IF/ID register did.
      h_d       = '{valid: 1'b0, inst: NOP_INST, npc: bus.in_npc};
      s_d.valid = 1'b0;
      state_d   = EMPTY;
    end else if (!stall) begin
      unique case (state_q)
        EMPTY: begin
          if (enq) begin
            h_d     = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (enq && deq) begin
            h_d = in_entry;
          end else if (enq) begin
            s_d     = in_entry;
            state_d = FULL;
          end else if (deq) begin
            h_d.valid = 1'b0;
            state_d   = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            h_d       = s_q;
            s_d.valid = 1'b0;
            state_d   = ONE;
          end
        end
        default: begin
          h_d.valid = 1'b0;
          s_d.valid = 1'b0;
          state_d   = EMPTY;
        end
      endcase
    end

    in_ready_d = occ_accepts(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      h_q        <= '{valid: 1'b0, inst: NOP_INST, npc: '0};
      s_q        <= '{valid: 1'b0, inst: NOP_INST, npc: '0};
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = h_q.valid ? h_q.inst : NOP_INST;
  assign bus.out_npc   = h_q.npc;

`ifdef STAGE_BUF_PERF_EN
  // A cycle with both stall and flush is attributed to flush only.
  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall & ~flush),
    .count (perf_stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (flush),
    .count (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed self-checking bench for pipeline_stage_buffer (honours STAGE_BUF_PERF_EN).
module tb_pipeline_stage_buffer;

  logic clk;
  logic reset;
  logic stall;
  logic flush;
  int   nvec;
  int   nfail;

`ifdef STAGE_BUF_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipeline_stage_buffer_if #(.INST_W(32), .PC_W(32)) bus ();

  pipeline_stage_buffer #(
    .INST_W   (32),
    .PC_W     (32),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
`ifdef STAGE_BUF_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] npc,
                       input logic ordy);
    bus.in_valid  = iv;
    bus.in_inst   = inst;
    bus.in_npc    = npc;
    bus.out_ready = ordy;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [31:0] inst,
                           input logic [31:0] npc, input logic ir);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, ".out_inst"},  64'(bus.out_inst),  64'(inst));
    check({tag, ".out_npc"},   64'(bus.out_npc),   64'(npc));
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(ir));
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset state
    tick();
    tick();
    check_out("reset", 1'b0, 32'h0, 32'h0, 1'b1);
`ifdef STAGE_BUF_PERF_EN
    check("perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
    check("perf_flush_rst", 64'(perf_flush_cnt), 64'd0);
`endif
    reset = 1'b0;

    // Single-cycle latency, then streaming one per cycle
    drive(1'b1, 32'h00A0_0013, 32'h5, 1'b1);
    tick();
    check_out("first", 1'b1, 32'h00A0_0013, 32'h5, 1'b1);
    drive(1'b1, 32'h11, 32'h6, 1'b1);
    tick();
    check_out("stream1", 1'b1, 32'h11, 32'h6, 1'b1);
    drive(1'b1, 32'h22, 32'h7, 1'b1);
    tick();
    check_out("stream2", 1'b1, 32'h22, 32'h7, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check_out("drain", 1'b0, 32'h0, 32'h7, 1'b1);

    // Back-pressure: A, B accepted, C held off, then in-order drain
    drive(1'b1, 32'hA1, 32'h10, 1'b0);
    tick();
    check_out("bp_a", 1'b1, 32'hA1, 32'h10, 1'b1);
    drive(1'b1, 32'hB2, 32'h11, 1'b0);
    tick();
    check_out("bp_b", 1'b1, 32'hA1, 32'h10, 1'b0);
    drive(1'b1, 32'hC3, 32'h12, 1'b0);
    tick();
    check_out("bp_c_held", 1'b1, 32'hA1, 32'h10, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check_out("bp_out_b", 1'b1, 32'hB2, 32'h11, 1'b1);
    tick();
    check_out("bp_out_c", 1'b1, 32'hC3, 32'h12, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check("bp_empty.out_valid", 64'(bus.out_valid), 64'd0);

    // Flush while FULL
    drive(1'b1, 32'hD4, 32'h20, 1'b0);
    tick();
    drive(1'b1, 32'hE5, 32'h21, 1'b0);
    tick();
    check("full.in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h77, 32'h40, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_out("flush", 1'b0, 32'h0, 32'h40, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check("flush_noacc.out_valid", 64'(bus.out_valid), 64'd0);

    // Stall hold for three cycles in state ONE
    drive(1'b1, 32'h1234, 32'h50, 1'b0);
    tick();
    check_out("hold_load", 1'b1, 32'h1234, 32'h50, 1'b1);
    drive(1'b1, 32'h9999, 32'h51, 1'b1);
    stall = 1'b1;
    #1;
    check_out("stall0", 1'b0, 32'h1234, 32'h50, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 1'b0, 32'h1234, 32'h50, 1'b0);
    end
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check_out("stall_rel", 1'b1, 32'h1234, 32'h50, 1'b1);
`ifdef STAGE_BUF_PERF_EN
    check("perf_stall_3", 64'(perf_stall_cnt), 64'd3);
    check("perf_flush_1", 64'(perf_flush_cnt), 64'd1);
`endif

    // Stall and flush together: flush wins
    drive(1'b1, 32'h88, 32'h60, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check_out("stall_flush", 1'b0, 32'h0, 32'h60, 1'b1);
`ifdef STAGE_BUF_PERF_EN
    check("perf_stall_sf", 64'(perf_stall_cnt), 64'd3);
    check("perf_flush_sf", 64'(perf_flush_cnt), 64'd2);
`endif

    // Reset while FULL and stalled
    drive(1'b1, 32'hF1, 32'h70, 1'b0);
    tick();
    drive(1'b1, 32'hF2, 32'h71, 1'b0);
    tick();
    check_out("prerst_full", 1'b1, 32'hF1, 32'h70, 1'b0);
    stall = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check_out("rst_mid", 1'b0, 32'h0, 32'h0, 1'b1);
`ifdef STAGE_BUF_PERF_EN
    check("perf_stall_clr", 64'(perf_stall_cnt), 64'd0);
    check("perf_flush_clr", 64'(perf_flush_cnt), 64'd0);
`endif
    tick();
    check("rst_idle.out_valid", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buffer.md
# pipeline_stage_buffer

Parametrised two-entry pipeline register with valid/ready handshake, hazard hold and branch flush, replacing fixed-width IF/ID-style stage registers. Sits between any two pipeline stages (first instance: fetch → decode). It carries an instruction word plus its next-PC, absorbs one cycle of downstream back-pressure without a combinational ready path, and emits a NOP when it has nothing valid.

## Interface
- `INST_W`, 32: instruction width.
- `PC_W`, 32: next-PC width.
- `NOP_INST`, 0: value driven on `out_inst` when the head entry is empty and on flush.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard hold from the hazard unit.
- `flush` in 1: kill from the PC control unit.
- `in_valid` in 1: upstream offers an entry.
- `in_ready` out 1: buffer accepts; registered.
- `in_inst` in INST_W: instruction.
- `in_npc` in PC_W: PC + 1.
- `out_valid` out 1: head entry presented to downstream.
- `out_ready` in 1: downstream consumes.
- `out_inst` out INST_W: head instruction, or NOP_INST.
- `out_npc` out PC_W: head next-PC.

## Operation
- Storage is a head entry H, which drives the outputs, and a skid entry S. Occupancy states: EMPTY (H and S invalid), ONE (H valid), FULL (H and S valid).
- Enqueue is `in_valid & in_ready & ~stall & ~flush`. Dequeue is `out_valid & out_ready` (out_valid is already gated by stall).
- Priority is reset > flush > stall > handshake. Flush beats stall.
- Flush: H and S are invalidated. out_inst becomes NOP_INST. out_npc takes in_npc, matching the legacy bubble behaviour. The state goes to EMPTY and the input is not accepted that cycle.
- Stall: H and S hold. in_ready=0 and out_valid=0 combinationally. No state change.
- EMPTY: on enqueue, load H → ONE.
- ONE:
  - enqueue & dequeue: H ← input, stay ONE.
  - enqueue only: S ← input → FULL.
  - dequeue only: → EMPTY.
- FULL: in_ready=0. On dequeue, H ← S → ONE. An input offered in the same cycle is not accepted.
- in_ready = (state != FULL), registered from next-state. out_valid = H valid & ~stall.
- Whenever H is invalid, out_inst = NOP_INST.
- Reset values: H and S invalid, state EMPTY, out_inst=NOP_INST, out_npc=0, out_valid=0, in_ready=1.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Latency from enqueue to out_valid is 1 cycle.
- Throughput is 1 entry per cycle while out_ready=1.
- There is no combinational path from out_ready to in_ready.
- Under out_ready=0 with continuous input, the buffer accepts 2 entries, then in_ready=0 from the following cycle.
- Reset asserted mid-operation discards both entries on the next edge, regardless of stall or flush.
- stall deasserting restores out_valid in the same cycle. No data loss.

## Configuration
- `STAGE_BUF_PERF_EN`: when defined, two extra outputs are added, `perf_stall_cnt` and `perf_flush_cnt`, each 32-bit.
  - They count cycles with stall=1 and cycles with flush=1.
  - Both saturate at 2^32−1 and clear on reset.
  - Flush-and-stall in the same cycle increments only the flush counter.
- When undefined, the ports and logic are absent and the block behaves identically otherwise.

## Structure
- Shared package `pipe_pkg` holds:
  - the occupancy state enum (EMPTY, ONE, FULL);
  - the default `NOP_INST` constant;
  - a packed entry typedef {valid, inst, npc}, sized by parameters at the instance.
- One sub-module, `sat_counter` (parametrised width, increment enable, synchronous clear), is instantiated twice under `STAGE_BUF_PERF_EN`. There are no other sub-modules.

## Test plan
- Reset, then in_valid=1 with inst=0x00A0_0013, npc=0x5, out_ready=1 → next cycle out_valid=1, out_inst=0x00A0_0013, out_npc=0x5. Then one entry per cycle, in order.
- out_ready=0, three back-to-back inputs A, B, C → A and B accepted, in_ready=0 from the third cycle. Then out_ready=1 → A, B, C emerge in order, with no loss.
- FULL, then flush=1 with in_npc=0x40 → next cycle out_valid=0, out_inst=NOP_INST, out_npc=0x40, in_ready=1, and the input that cycle is not accepted.
- Hold state ONE with H=0x1234, assert stall for 3 cycles with in_valid=1 → out_valid=0 and in_ready=0 throughout, H unchanged. On release, out_valid=1 with 0x1234.
- stall=1 and flush=1 together → flush wins and the buffer is EMPTY. With `STAGE_BUF_PERF_EN`, perf_flush_cnt increments by 1 and perf_stall_cnt is unchanged.
- Reset pulse while FULL and stalled → next cycle out_valid=0, out_inst=NOP_INST, out_npc=0, in_ready=1.
